// File: rtl/multu_seq.sv
// multu_seq: radix-2 shift-add unsigned multiplier for the EX stage.
// Owns the HI/LO registers, serves mfhi/mflo reads, and stalls the pipeline
// while a product is in flight.
//
// Handshake: a multiply is accepted on any rising edge where Multu=1 and the
// sequencer is IDLE. Outside IDLE, any multu or mfhi/mflo request raises
// stall combinationally. The requester must hold the request until stall
// falls. There is no separate ready signal: !stall means "accepted/served".
module multu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Multu,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hilo_rdata,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH:0]     sum;
    logic               read_req;

    // Register update; reset abandons any product in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Next-state and datapath: one shift-add step per RUN cycle.
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        // The carry out of the partial sum lands in the accumulator MSB.
        sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        case (state_q)
            IDLE: begin
                if (Multu) begin
                    mcand_d = opA;
                    acc_d   = {{WIDTH{1'b0}}, opB};
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = {sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                hi_d    = acc_q[2*WIDTH-1:WIDTH];
                lo_d    = acc_q[WIDTH-1:0];
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // HI/LO read port and pipeline stall, both without a register stage.
    always_comb begin
        read_req = (sel == 2'b01) || (sel == 2'b10);
        stall    = (state_q != IDLE) && (Multu || read_req);
        case (sel)
            2'b01:   hilo_rdata = hi_q;
            2'b10:   hilo_rdata = lo_q;
            default: hilo_rdata = '0;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_multu_seq.sv
// Testbench for multu_seq: a product model from plain 64-bit arithmetic and
// a cycle-count timing model taken from the documented latency.
module tb_multu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         Multu;
    logic [1:0]   sel;
    logic [W-1:0] opA, opB;
    logic         stall, busy, done;
    logic [W-1:0] hi, lo, hilo_rdata;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;

    // Architectural HI/LO the bench expects.
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;

    multu_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .Multu      (Multu),
        .sel        (sel),
        .opA        (opA),
        .opB        (opB),
        .stall      (stall),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo),
        .hilo_rdata (hilo_rdata),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] wa, wb;
        wa = {{W{1'b0}}, a};
        wb = {{W{1'b0}}, b};
        return wa * wb;
    endfunction

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; Multu = 1'b0; sel = 2'b00; opA = '0; opB = '0;
        #3;
        checks++;
        if ({busy, done, stall} !== 3'b000 || hi !== '0 || lo !== '0 || hilo_rdata !== '0) begin
            errors++;
            $display("FAIL reset_values: busy=%b done=%b stall=%b hi=%h lo=%h rdata=%h, want all 0",
                     busy, done, stall, hi, lo, hilo_rdata);
        end
        step();
        step();
        rst = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || hi !== '0) begin
            errors++;
            $display("FAIL reset_release: busy=%b hi=%h, want 0 0", busy, hi);
        end
    endtask

    // Full multiply with per-cycle timing checks. Entered and left 1 ns after an edge.
    task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b, input string name);
        logic [2*W-1:0] p;
        p = ref_mul(a, b);
        Multu = 1'b1; opA = a; opB = b; sel = 2'b00;
        #1;
        checks++;
        if (stall !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_start: stall=%b busy=%b, want 0 0", name, stall, busy);
        end
        step();
        Multu = 1'b0; opA = $urandom; opB = $urandom;
        for (int k = 1; k <= W + 1; k++) begin
            #1;
            checks++;
            if (busy !== 1'b1 || done !== (k == W + 1) || hi !== model_hi || lo !== model_lo) begin
                errors++;
                $display("FAIL %s_cycle%0d: busy=%b done=%b hi=%h lo=%h, want 1 %b %h %h",
                         name, k, busy, done, hi, lo, (k == W + 1), model_hi, model_lo);
            end
            step();
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== p[2*W-1:W] || lo !== p[W-1:0]) begin
            errors++;
            $display("FAIL %s_result: busy=%b done=%b hi=%h lo=%h, want 0 0 %h %h",
                     name, busy, done, hi, lo, p[2*W-1:W], p[W-1:0]);
        end
        model_hi = p[2*W-1:W];
        model_lo = p[W-1:0];
    endtask

    task automatic test_directed();
        run_mult(32'd3, 32'd5, "mul_3x5");
        run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max");
        run_mult(32'h8000_0000, 32'h0000_0002, "mul_msb");
        run_mult(32'h0, 32'hFFFF_FFFF, "mul_zero_a");
        run_mult(32'h1234_5678, 32'h0, "mul_zero_b");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            run_mult($urandom, $urandom, "mul_rand");
        end
    endtask

    // mfhi issued two cycles after start waits for the product.
    task automatic test_mfhi_stall();
        logic [2*W-1:0] p;
        logic [W-1:0] a, b;
        a = 32'hDEAD_BEEF ^ $urandom_range(0, 255);
        b = 32'h1234_5678;
        p = ref_mul(a, b);
        Multu = 1'b1; opA = a; opB = b; sel = 2'b00;
        step();
        Multu = 1'b0;
        step();
        sel = 2'b01;
        for (int k = 2; k <= W + 1; k++) begin
            #1;
            checks++;
            if (stall !== 1'b1 || hilo_rdata !== model_hi) begin
                errors++;
                $display("FAIL mfhi_wait%0d: stall=%b rdata=%h, want 1 %h", k, stall, hilo_rdata, model_hi);
            end
            step();
        end
        #1;
        checks++;
        if (stall !== 1'b0 || hilo_rdata !== p[2*W-1:W]) begin
            errors++;
            $display("FAIL mfhi_release: stall=%b rdata=%h, want 0 %h", stall, hilo_rdata, p[2*W-1:W]);
        end
        sel = 2'b10;
        #1;
        checks++;
        if (hilo_rdata !== p[W-1:0]) begin
            errors++;
            $display("FAIL mflo_read: rdata=%h, want %h", hilo_rdata, p[W-1:0]);
        end
        sel = 2'b00;
        #1;
        checks++;
        if (hilo_rdata !== '0) begin
            errors++;
            $display("FAIL sel_none: rdata=%h, want 0", hilo_rdata);
        end
        model_hi = p[2*W-1:W];
        model_lo = p[W-1:0];
        step();
    endtask

    // A second multu held by stall, accepted on the first IDLE edge.
    task automatic test_back_to_back();
        Multu = 1'b1; opA = 32'd7; opB = 32'd6; sel = 2'b00;
        step();
        opA = 32'd2; opB = 32'd9;
        for (int k = 1; k <= W + 1; k++) begin
            #1;
            checks++;
            if (stall !== 1'b1 || busy !== 1'b1 || done !== (k == W + 1)) begin
                errors++;
                $display("FAIL b2b_hold%0d: stall=%b busy=%b done=%b, want 1 1 %b",
                         k, stall, busy, done, (k == W + 1));
            end
            step();
        end
        #1;
        checks++;
        if (stall !== 1'b0 || busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h2A) begin
            errors++;
            $display("FAIL b2b_first: stall=%b busy=%b hi=%h lo=%h, want 0 0 0 2a", stall, busy, hi, lo);
        end
        step();
        Multu = 1'b0;
        for (int k = 1; k <= W + 1; k++) begin
            #1;
            checks++;
            if (busy !== 1'b1 || done !== (k == W + 1) || lo !== 32'h2A) begin
                errors++;
                $display("FAIL b2b_second%0d: busy=%b done=%b lo=%h, want 1 %b 2a",
                         k, busy, done, lo, (k == W + 1));
            end
            step();
        end
        checks++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h12) begin
            errors++;
            $display("FAIL b2b_result: busy=%b hi=%h lo=%h, want 0 0 12", busy, hi, lo);
        end
        model_hi = 32'h0;
        model_lo = 32'h12;
    endtask

    // Read and multu in the same IDLE cycle: read returns the old LO.
    task automatic test_same_cycle_read();
        logic [2*W-1:0] p;
        logic [W-1:0] a, b;
        a = $urandom; b = $urandom;
        p = ref_mul(a, b);
        Multu = 1'b1; opA = a; opB = b; sel = 2'b10;
        #1;
        checks++;
        if (stall !== 1'b0 || hilo_rdata !== model_lo) begin
            errors++;
            $display("FAIL same_cycle_read: stall=%b rdata=%h, want 0 %h", stall, hilo_rdata, model_lo);
        end
        step();
        Multu = 1'b0; sel = 2'b00;
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_start: busy=%b, want 1", busy);
        end
        for (int k = 1; k <= W + 1; k++) step();
        checks++;
        if (hi !== p[2*W-1:W] || lo !== p[W-1:0]) begin
            errors++;
            $display("FAIL same_cycle_result: hi=%h lo=%h, want %h %h", hi, lo, p[2*W-1:W], p[W-1:0]);
        end
        model_hi = p[2*W-1:W];
        model_lo = p[W-1:0];
    endtask

    // Asynchronous reset at cnt=10 discards the product.
    task automatic test_reset_mid_run();
        run_mult(32'h1234_5678, 32'h9ABC_DEF0, "mul_pre_reset");
        Multu = 1'b1; opA = $urandom; opB = $urandom; sel = 2'b00;
        step();
        Multu = 1'b0; sel = 2'b01;
        for (int k = 1; k < 11; k++) step();
        #1;
        checks++;
        if (stall !== 1'b1 || busy !== 1'b1 || hi !== model_hi) begin
            errors++;
            $display("FAIL pre_reset_run: stall=%b busy=%b hi=%h, want 1 1 %h", stall, busy, hi, model_hi);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, done, stall} !== 3'b000 || hi !== '0 || lo !== '0 || hilo_rdata !== '0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: busy=%b done=%b stall=%b hi=%h lo=%h rdata=%h st=%0d, want all 0",
                     busy, done, stall, hi, lo, hilo_rdata, dbg_state);
        end
        step();
        rst = 1'b1; sel = 2'b00;
        model_hi = '0;
        model_lo = '0;
        for (int k = 0; k < W + 4; k++) begin
            #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || hi !== '0 || lo !== '0) begin
                errors++;
                $display("FAIL post_reset%0d: done=%b busy=%b hi=%h lo=%h, want 0 0 0 0", k, done, busy, hi, lo);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_mfhi_stall();
        test_back_to_back();
        test_same_cycle_read();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
